// File: rtl/pio_irq_sequencer.sv
// Avalon-MM master that arms the 16-bit input PIO's IRQ mask and services its level interrupt.
// Each sampled event is handed off on valid/ready, and its fired bits are masked for a holdoff window.
module pio_irq_sequencer #(
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int READ_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata,
  input  logic        pio_irq,
  input  logic [15:0] cfg_mask,
  input  logic        cfg_load,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [15:0] evt_data,
  output logic [15:0] evt_active,
  output logic [15:0] evt_count,
  output logic        busy
);

  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, ARMED, WR_CFG, RD_ADDR, RD_WAIT, EMIT, DISARM, HOLDOFF, REARM
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     shadow_mask, live_mask, shadow_nxt, sample_active;
  logic            pend_load;
  logic [HW-1:0]   hold_cnt;
  logic [1:0]      rd_cnt;
  logic            rd_done;
  logic [1:0]      addr_nxt;
  logic            cs_nxt, wr_n_nxt;
  logic [15:0]     wdat_nxt;
  logic            unused_rd_hi;

  assign unused_rd_hi  = ^pio_readdata[31:16];
  // A load arriving on the same edge as a mask write must be the value written.
  assign shadow_nxt    = cfg_load ? cfg_mask : shadow_mask;
  assign rd_done       = (rd_cnt == 2'(READ_LATENCY - 1));
  assign sample_active = pio_readdata[15:0] & live_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend_load) state_nxt = WR_CFG;
      ARMED:   if (pend_load) state_nxt = WR_CFG;
               else if (pio_irq) state_nxt = RD_ADDR;
      WR_CFG,
      REARM:   state_nxt = (pio_writedata[15:0] != 16'h0) ? ARMED : IDLE;
      RD_ADDR: state_nxt = RD_WAIT;
      RD_WAIT: if (rd_done) state_nxt = (sample_active != 16'h0) ? EMIT : ARMED;
      EMIT:    if (evt_ready) state_nxt = DISARM;
      DISARM:  state_nxt = (HOLDOFF_CYCLES == 0) ? REARM : HOLDOFF;
      HOLDOFF: if (hold_cnt <= HW'(1)) state_nxt = REARM;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    addr_nxt = 2'd0;
    cs_nxt   = 1'b0;
    wr_n_nxt = 1'b1;
    wdat_nxt = 16'h0;
    case (state_nxt)
      WR_CFG, REARM: begin
        addr_nxt = 2'd2; cs_nxt = 1'b1; wr_n_nxt = 1'b0; wdat_nxt = shadow_nxt;
      end
      DISARM: begin
        addr_nxt = 2'd2; cs_nxt = 1'b1; wr_n_nxt = 1'b0; wdat_nxt = live_mask & ~evt_active;
      end
      RD_ADDR: cs_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_address    <= 2'd0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= 32'h0;
      evt_valid      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      pio_address    <= addr_nxt;
      pio_chipselect <= cs_nxt;
      pio_write_n    <= wr_n_nxt;
      pio_writedata  <= {16'h0, wdat_nxt};
      evt_valid      <= (state_nxt == EMIT);
      busy           <= !(state_nxt == IDLE || state_nxt == ARMED);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_mask <= 16'h0;
      live_mask   <= 16'h0;
      pend_load   <= 1'b0;
      hold_cnt    <= '0;
      rd_cnt      <= 2'd0;
      evt_data    <= 16'h0;
      evt_active  <= 16'h0;
      evt_count   <= 16'h0;
    end else begin
      if (cfg_load) begin
        shadow_mask <= cfg_mask;
        pend_load   <= 1'b1;
      end else if ((state == IDLE || state == ARMED) && pend_load) begin
        pend_load   <= 1'b0;
      end
      case (state)
        WR_CFG, REARM: live_mask <= pio_writedata[15:0];
        DISARM: begin
          live_mask <= pio_writedata[15:0];
          hold_cnt  <= HW'(HOLDOFF_CYCLES);
        end
        RD_ADDR: rd_cnt <= 2'd0;
        RD_WAIT: begin
          rd_cnt <= rd_cnt + 2'd1;
          if (rd_done && sample_active != 16'h0) begin
            evt_data   <= pio_readdata[15:0];
            evt_active <= sample_active;
          end
        end
        EMIT:    if (evt_ready) evt_count <= evt_count + 16'd1;
        HOLDOFF: hold_cnt <= hold_cnt - HW'(1);
        default: ;
      endcase
    end
  end

endmodule
